trans_scheduler: RTL and testbench

- Round-robin scheduler that shares one trans_validator between NUM_REQ transaction sources.
- Selects one pending 128-bit transaction, drives the validator's data_i/valid_i, and holds it until the validator's ack_o.
- Returns a one-cycle ack to the winning source.
- Tags each approved transaction (validator valid_o) with its source index. Keeps issued/approved statistics and a stuck-handshake watchdog.

---
 rtl/trans_pkg.sv | 30 +++
 rtl/rr_arbiter.sv | 38 +++
 rtl/trans_scheduler.sv | 124 ++++++++++++
 tb/tb_trans_scheduler.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/trans_pkg.sv
`default_nettype none
// ============================================================================
// Module   : trans_pkg
// Brief    : Shared transaction layout and scheduler state type.
// Revision : 1.0 - initial release
// ============================================================================
package trans_pkg;

    localparam int TRANS_W         = 128;
    localparam int BIT_BLOCK_START = 9;

    localparam int SENDER_MSB   = 127;
    localparam int SENDER_LSB   = 80;
    localparam int RECEIVER_MSB = 79;
    localparam int RECEIVER_LSB = 32;
    localparam int AMOUNT_MSB   = 31;
    localparam int AMOUNT_LSB   = 10;
    localparam int AMOUNT_W     = AMOUNT_MSB - AMOUNT_LSB + 1;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } sched_state_t;

    function automatic logic [AMOUNT_W-1:0] trans_amount(input logic [TRANS_W-1:0] t);
        return t[AMOUNT_MSB:AMOUNT_LSB];
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Brief    : Combinational first-set search starting at a rotating pointer.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         i_req,
    input  logic [$clog2(NUM_REQ)-1:0] i_ptr,
    output logic [$clog2(NUM_REQ)-1:0] o_grant,
    output logic                       o_any_req
);

    localparam int C_IDX_W = $clog2(NUM_REQ);

    logic [C_IDX_W:0] w_idx;

    // Walk offsets from farthest to nearest so the nearest set bit wins.
    always_comb begin
        o_grant   = '0;
        o_any_req = 1'b0;
        w_idx     = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_idx = {1'b0, i_ptr} + (C_IDX_W + 1)'(k);
            if (w_idx >= (C_IDX_W + 1)'(NUM_REQ)) begin
                w_idx = w_idx - (C_IDX_W + 1)'(NUM_REQ);
            end
            if (i_req[w_idx[C_IDX_W-1:0]]) begin
                o_grant   = w_idx[C_IDX_W-1:0];
                o_any_req = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/trans_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : trans_scheduler
// Brief    : Round-robin share of one trans_validator among NUM_REQ sources.
// Revision : 1.0 - initial release
// ============================================================================
module trans_scheduler
    import trans_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 16384,
    parameter int CNT_W   = 32
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_REQ-1:0]           req_valid_i,
    input  logic [NUM_REQ*TRANS_W-1:0]   req_data_i,
    output logic [NUM_REQ-1:0]           req_ack_o,
    output logic [TRANS_W-1:0]           val_data_o,
    output logic                         val_valid_o,
    input  logic                         val_ack_i,
    input  logic [TRANS_W-1:0]           val_data_i,
    input  logic                         val_valid_i,
    output logic                         out_valid_o,
    output logic [TRANS_W-1:0]           out_data_o,
    output logic [$clog2(NUM_REQ)-1:0]   out_src_o,
    output logic [CNT_W-1:0]             issued_cnt_o,
    output logic [CNT_W-1:0]             approved_cnt_o,
    output logic                         err_timeout_o
);

    localparam int                 C_IDX_W    = $clog2(NUM_REQ);
    localparam int                 C_TMR_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [C_TMR_W-1:0] C_TMR_LAST = C_TMR_W'(TIMEOUT - 1);

    sched_state_t         r_state;
    logic [C_IDX_W-1:0]   r_grant;
    logic [C_IDX_W-1:0]   r_rr_ptr;
    logic [C_IDX_W-1:0]   r_last_src;
    logic [C_TMR_W-1:0]   r_timer;

    logic [C_IDX_W-1:0]   w_grant;
    logic                 w_any_req;
    logic [TRANS_W-1:0]   w_req_data [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign w_req_data[g] = req_data_i[g*TRANS_W +: TRANS_W];
    end

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .i_req     (req_valid_i),
        .i_ptr     (r_rr_ptr),
        .o_grant   (w_grant),
        .o_any_req (w_any_req)
    );

    // Issue FSM: the selected transaction is held on the validator port until ack.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_grant       <= '0;
            r_rr_ptr      <= '0;
            r_last_src    <= '0;
            r_timer       <= '0;
            req_ack_o     <= '0;
            val_data_o    <= '0;
            val_valid_o   <= 1'b0;
            issued_cnt_o  <= '0;
            err_timeout_o <= 1'b0;
        end else begin
            req_ack_o <= '0;
            case (r_state)
                IDLE: begin
                    if (w_any_req) begin
                        r_grant     <= w_grant;
                        val_data_o  <= w_req_data[w_grant];
                        val_valid_o <= 1'b1;
                        r_timer     <= '0;
                        r_state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (val_ack_i) begin
                        val_valid_o        <= 1'b0;
                        req_ack_o[r_grant] <= 1'b1;
                        r_last_src         <= r_grant;
                        r_rr_ptr           <= (r_grant == C_IDX_W'(NUM_REQ - 1)) ? '0
                                                                                 : r_grant + C_IDX_W'(1);
                        issued_cnt_o       <= issued_cnt_o + CNT_W'(1);
                        r_timer            <= '0;
                        r_state            <= IDLE;
                    end else if (r_timer == C_TMR_LAST) begin
                        // Saturate and keep waiting; the flag stays until reset.
                        err_timeout_o <= 1'b1;
                    end else begin
                        r_timer <= r_timer + C_TMR_W'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // A coincident ack has not yet moved r_last_src, so the approval keeps the older tag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_o    <= 1'b0;
            out_data_o     <= '0;
            out_src_o      <= '0;
            approved_cnt_o <= '0;
        end else begin
            out_valid_o <= val_valid_i;
            if (val_valid_i) begin
                out_data_o     <= val_data_i;
                out_src_o      <= r_last_src;
                approved_cnt_o <= approved_cnt_o + CNT_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_trans_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_trans_scheduler
// Brief    : Directed bench for trans_scheduler with a transaction-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_trans_scheduler;

    localparam int N  = 4;
    localparam int TO = 16;
    localparam int CW = 32;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic [N-1:0]     req_valid_i = '0;
    logic [N*128-1:0] req_data_i = '0;
    logic [N-1:0]     req_ack_o;
    logic [127:0]     val_data_o;
    logic             val_valid_o;
    logic             val_ack_i = 1'b0;
    logic [127:0]     val_data_i = '0;
    logic             val_valid_i = 1'b0;
    logic             out_valid_o;
    logic [127:0]     out_data_o;
    logic [1:0]       out_src_o;
    logic [CW-1:0]    issued_cnt_o;
    logic [CW-1:0]    approved_cnt_o;
    logic             err_timeout_o;

    trans_scheduler #(.NUM_REQ(N), .TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid_i    (req_valid_i),
        .req_data_i     (req_data_i),
        .req_ack_o      (req_ack_o),
        .val_data_o     (val_data_o),
        .val_valid_o    (val_valid_o),
        .val_ack_i      (val_ack_i),
        .val_data_i     (val_data_i),
        .val_valid_i    (val_valid_i),
        .out_valid_o    (out_valid_o),
        .out_data_o     (out_data_o),
        .out_src_o      (out_src_o),
        .issued_cnt_o   (issued_cnt_o),
        .approved_cnt_o (approved_cnt_o),
        .err_timeout_o  (err_timeout_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model of the scheduler ----------------
    bit            m_busy = 0;
    int            m_cur = 0, m_ptr = 0, m_last = 0, m_wait = 0;
    logic          e_vv = 0, e_ov = 0, e_err = 0;
    logic [127:0]  e_vd = '0, e_od = '0;
    logic [N-1:0]  e_ack = '0;
    logic [1:0]    e_os = '0;
    logic [CW-1:0] e_iss = '0, e_appr = '0;

    task automatic model_reset();
        m_busy = 0; m_cur = 0; m_ptr = 0; m_last = 0; m_wait = 0;
        e_vv = 0; e_ov = 0; e_err = 0; e_vd = '0; e_od = '0;
        e_ack = '0; e_os = '0; e_iss = '0; e_appr = '0;
    endtask

    task automatic model_step();
        int s;
        e_ack = '0;
        if (val_valid_i) begin
            e_ov = 1; e_od = val_data_i; e_os = 2'(m_last); e_appr = e_appr + 1;
        end else begin
            e_ov = 0;
        end
        if (!m_busy) begin
            s = -1;
            for (int k = 0; k < N; k++)
                if (s < 0 && req_valid_i[(m_ptr + k) % N]) s = (m_ptr + k) % N;
            if (s >= 0) begin
                m_busy = 1; m_cur = s; m_wait = 0;
                e_vv = 1; e_vd = req_data_i[s*128 +: 128];
            end
        end else if (val_ack_i) begin
            e_vv = 0; e_ack[m_cur] = 1'b1; m_last = m_cur;
            m_ptr = (m_cur + 1) % N; e_iss = e_iss + 1; m_busy = 0;
        end else begin
            m_wait++;
            if (m_wait >= TO) e_err = 1;
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else        model_step();
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("val_valid",   val_valid_o,    e_vv);
            chk("val_data",    val_data_o,     e_vd);
            chk("req_ack",     req_ack_o,      e_ack);
            chk("out_valid",   out_valid_o,    e_ov);
            chk("out_data",    out_data_o,     e_od);
            chk("out_src",     out_src_o,      e_os);
            chk("issued_cnt",  issued_cnt_o,   e_iss);
            chk("approved",    approved_cnt_o, e_appr);
            chk("err_timeout", err_timeout_o,  e_err);
            if (m_busy) chk("req_held_in_issue", req_valid_i[m_cur], 1'b1);
        end
    end

    // ---------------- sources and validator stand-in ----------------
    typedef struct {
        int           due;
        logic [127:0] d;
    } appr_t;

    logic [127:0] sdata [N][8];
    int           scnt [N];
    int           sidx [N];
    appr_t        apq[$];
    int           seen = 0, ack_dly = 1, appr_dly = 1, cyc = 0;
    bit           never_ack = 0;
    int           grants[$];
    int           outs[$];
    logic [127:0] outd[$];
    logic [N-1:0] ack_raw[$];

    function automatic logic [127:0] mk(input int src, input int amt, input int tag);
        logic [127:0] t;
        t = '0;
        t[127:80] = 48'h0A00 + 48'(src);
        t[79:32]  = 48'hB000 + 48'(tag);
        t[31:10]  = 22'(amt);
        t[9]      = 1'b1;
        t[8:0]    = 9'(tag);
        return t;
    endfunction

    function automatic bit all_done();
        bit r;
        r = 1;
        for (int i = 0; i < N; i++) if (sidx[i] < scnt[i]) r = 0;
        return r;
    endfunction

    task automatic add_txn(input int src, input logic [127:0] d);
        sdata[src][scnt[src]] = d;
        scnt[src]++;
    endtask

    task automatic drive_src();
        for (int i = 0; i < N; i++) begin
            req_valid_i[i] = (sidx[i] < scnt[i]);
            req_data_i[i*128 +: 128] = (sidx[i] < scnt[i]) ? sdata[i][sidx[i] & 7] : '0;
        end
    endtask

    task automatic drive_val();
        appr_t a;
        val_ack_i   = 1'b0;
        val_valid_i = 1'b0;
        val_data_i  = {$urandom, $urandom, $urandom, $urandom};
        if (val_valid_o) begin
            seen++;
            if (!never_ack && seen >= ack_dly) begin
                val_ack_i = 1'b1;
                seen = 0;
                if (val_data_o[31:10] <= 22'd100) begin
                    a.due = cyc + appr_dly;
                    a.d   = val_data_o;
                    apq.push_back(a);
                end
            end
        end else begin
            seen = 0;
        end
        if (apq.size() > 0 && apq[0].due == cyc) begin
            val_valid_i = 1'b1;
            val_data_i  = apq[0].d;
            void'(apq.pop_front());
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (req_ack_o != '0) ack_raw.push_back(req_ack_o);
        for (int i = 0; i < N; i++)
            if (req_ack_o[i]) begin grants.push_back(i); sidx[i]++; end
        if (out_valid_o) begin
            outs.push_back(int'(out_src_o));
            outd.push_back(out_data_o);
        end
        drive_src();
        drive_val();
    endtask

    task automatic run_idle(input int budget);
        int n;
        n = 0;
        forever begin
            step();
            n++;
            if ((all_done() && apq.size() == 0 && !val_valid_o) || n >= budget) break;
        end
        step();
        step();
        chk("run_budget", n < budget, 1'b1);
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_ctrl"}, {req_ack_o, val_valid_o, out_valid_o, out_src_o, err_timeout_o}, '0);
        chk({nm, "_val_data"}, val_data_o, '0);
        chk({nm, "_out_data"}, out_data_o, '0);
        chk({nm, "_counts"}, {issued_cnt_o, approved_cnt_o}, '0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        for (int i = 0; i < N; i++) begin scnt[i] = 0; sidx[i] = 0; end
        never_ack = 0; ack_dly = 1; appr_dly = 1; seen = 0;
        apq.delete();
        #1;
        drive_src();
        drive_val();
        step();
        chk_zero("reset");
        step();
        rst_n = 1'b1;
        grants.delete(); outs.delete(); outd.delete(); ack_raw.delete();
    endtask

    int exp_rr [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
    int k;

    initial begin
        #2;
        // Single source 2
        do_reset();
        add_txn(2, 128'hA5A5_0000_0000_0000_0000_0000_0000_0200);
        drive_src();
        run_idle(50);
        chk("t1_grant_count", grants.size(), 1);
        chk("t1_ack_onehot", (ack_raw.size() > 0) ? ack_raw[0] : 4'b0000, 4'b0100);
        chk("t1_out_src", (outs.size() > 0) ? outs[0] : -1, 2);
        chk("t1_out_data", (outd.size() > 0) ? outd[0] : '0,
            128'hA5A5_0000_0000_0000_0000_0000_0000_0200);
        chk("t1_counts", {issued_cnt_o, approved_cnt_o}, {32'd1, 32'd1});

        // All four continuously requesting, two each
        do_reset();
        for (int j = 0; j < 2; j++)
            for (int i = 0; i < N; i++) add_txn(i, mk(i, 10, j));
        drive_src();
        run_idle(200);
        chk("t2_grant_count", grants.size(), 8);
        for (int i = 0; i < 8; i++)
            chk("t2_rr_order", (i < grants.size()) ? grants[i] : -1, exp_rr[i]);
        chk("t2_ack_pulses", ack_raw.size(), 8);
        chk("t2_issued", issued_cnt_o, 8);

        // Three rejections out of five
        do_reset();
        add_txn(0, mk(0, 50, 1));
        add_txn(1, mk(1, 200, 2));
        add_txn(2, mk(2, 200, 3));
        add_txn(3, mk(3, 80, 4));
        add_txn(0, mk(0, 200, 5));
        drive_src();
        run_idle(200);
        chk("t3_out_count", outs.size(), 2);
        chk("t3_src0", (outs.size() > 0) ? outs[0] : -1, 0);
        chk("t3_src1", (outs.size() > 1) ? outs[1] : -1, 3);
        chk("t3_data1", (outd.size() > 1) ? outd[1] : '0, mk(3, 80, 4));
        chk("t3_counts", {issued_cnt_o, approved_cnt_o}, {32'd5, 32'd2});

        // Watchdog: validator stalls, then acks late
        do_reset();
        never_ack = 1;
        add_txn(0, mk(0, 5, 9));
        drive_src();
        k = 0;
        while (!val_valid_o && k < 10) begin step(); k++; end
        chk("t4_issue_seen", val_valid_o, 1'b1);
        k = 0;
        while (!err_timeout_o && k < 40) begin step(); k++; end
        chk("t4_timeout_edge", k, 16);
        for (int i = 0; i < 10; i++) step();
        chk("t4_still_holding", {val_valid_o, err_timeout_o}, 2'b11);
        chk("t4_no_issue", issued_cnt_o, 0);
        never_ack = 0;
        run_idle(50);
        chk("t4_late_ack", issued_cnt_o, 1);
        chk("t4_err_sticky", err_timeout_o, 1'b1);

        // Approval of source 1 coincides with ack of source 3
        do_reset();
        appr_dly = 2;
        add_txn(1, mk(1, 10, 11));
        add_txn(3, mk(3, 20, 13));
        drive_src();
        run_idle(100);
        chk("t5_grant_count", grants.size(), 2);
        chk("t5_first_tag", (outs.size() > 0) ? outs[0] : -1, 1);
        chk("t5_second_tag", (outs.size() > 1) ? outs[1] : -1, 3);

        // Asynchronous reset in the middle of an issue
        do_reset();
        add_txn(2, mk(2, 1, 20));
        drive_src();
        run_idle(50);
        chk("t6_pre_grant", (grants.size() > 0) ? grants[0] : -1, 2);
        never_ack = 1;
        add_txn(0, mk(0, 1, 21));
        add_txn(3, mk(3, 1, 23));
        drive_src();
        k = 0;
        while (!val_valid_o && k < 10) begin step(); k++; end
        chk("t6_issue_seen", val_valid_o, 1'b1);
        step();
        step();
        #2;
        rst_n = 1'b0;
        #1;
        chk_zero("t6_async");
        grants.delete(); outs.delete(); outd.delete(); ack_raw.delete();
        apq.delete();
        seen = 0;
        step();
        rst_n = 1'b1;
        never_ack = 0;
        run_idle(80);
        chk("t6_grant_count", grants.size(), 2);
        chk("t6_first_after_rst", (grants.size() > 0) ? grants[0] : -1, 0);
        chk("t6_second_after_rst", (grants.size() > 1) ? grants[1] : -1, 3);
        chk("t6_issued", issued_cnt_o, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
